// File: rtl/bj_pkg.sv
// Shared BlackJack definitions: deck geometry, dealer state encoding, points rule.
// Used by the dealer, its card decoder and the hand scorer.
// Pure declarations; no logic or timing of its own.
package bj_pkg;

  localparam int DECK_SIZE = 52;
  localparam int RANKS     = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    PROBE = 2'd2,
    DONE  = 2'd3
  } dealer_state_e;

  // Ace counts 1 here; the hand scorer decides whether to promote it to 11.
  function automatic logic [3:0] bj_points(input logic [3:0] rank);
    return (rank > 4'd10) ? 4'd10 : rank;
  endfunction

endpackage

// File: rtl/card_decode.sv
// Card index (0..51) to rank, suit and BlackJack points.
// Purely combinational, zero latency.
// No handshake; the result follows idx_i directly.
module card_decode
  import bj_pkg::*;
(
  input  logic [5:0] idx_i,
  output logic [3:0] rank_o,
  output logic [1:0] suit_o,
  output logic [3:0] points_o
);

  localparam logic [5:0] R1 = 6'(RANKS);
  localparam logic [5:0] R2 = 6'(2 * RANKS);
  localparam logic [5:0] R3 = 6'(3 * RANKS);

  logic [5:0] rem;
  logic [1:0] unused_rem_hi;

  // Suit is the 13-card block the index falls in; rem is the position within it.
  always_comb begin
    suit_o = 2'd0;
    rem    = idx_i;
    if (idx_i >= R3) begin
      suit_o = 2'd3;
      rem    = idx_i - R3;
    end else if (idx_i >= R2) begin
      suit_o = 2'd2;
      rem    = idx_i - R2;
    end else if (idx_i >= R1) begin
      suit_o = 2'd1;
      rem    = idx_i - R1;
    end
  end

  // rem is always below 13, so the top bits carry no information.
  assign unused_rem_hi = rem[5:4];
  assign rank_o        = rem[3:0] + 4'd1;
  assign points_o      = bj_points(rank_o);

endmodule

// File: rtl/card_dealer.sv
// Deals one not-yet-dealt card per request after the 2 s delay, tracks deck usage.
// Latency: PROBE one cycle after i_TwoSec, strobe one cycle later plus one per occupied slot.
// Requests are only taken in IDLE with a non-empty deck; o_Busy marks when they are ignored.
module card_dealer
  import bj_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int DECK_SIZE = 52
) (
  input  logic       clk_2K,
  input  logic       i_Reset,
  input  logic       i_Request,
  input  logic       i_Shuffle,
  input  logic       i_TwoSec,
  output logic       o_ActCounter,
  output logic       o_RstCounter,
  output logic [3:0] o_Rank,
  output logic [1:0] o_Suit,
  output logic [3:0] o_Points,
  output logic       o_CardValid,
  output logic       o_Busy,
  output logic       o_DeckEmpty,
  output logic [5:0] o_CardsLeft
);

  localparam logic [WIDTH-1:0] DECK_W    = WIDTH'(DECK_SIZE);
  localparam logic [5:0]       LAST_IDX  = 6'(DECK_SIZE - 1);
  localparam logic [5:0]       FULL_DECK = 6'(DECK_SIZE);

  logic [WIDTH-1:0]     free_q;
  dealer_state_e        state_q;
  logic [5:0]           idx_q;
  logic [5:0]           idx_d;
  logic [DECK_SIZE-1:0] used_q;
  logic [5:0]           cards_left_q;
  logic                 act_q;
  logic                 rst_cnt_q;
  logic                 valid_q;
  logic [3:0]           rank_q;
  logic [1:0]           suit_q;
  logic [3:0]           points_q;

  logic [WIDTH-1:0]     seed_mod;
  logic [5:0]           seed_idx;
  logic [WIDTH-7:0]     unused_seed_hi;
  logic [3:0]           dec_rank;
  logic [1:0]           dec_suit;
  logic [3:0]           dec_points;
  logic                 deck_empty;

  // The seed is the request timing, reduced straight to a deck position.
  assign seed_mod       = free_q % DECK_W;
  assign seed_idx       = seed_mod[5:0];
  assign unused_seed_hi = seed_mod[WIDTH-1:6];

  // Linear probe to the next slot, wrapping past the last card.
  assign idx_d      = (idx_q == LAST_IDX) ? 6'd0 : idx_q + 6'd1;
  assign deck_empty = (cards_left_q == 6'd0);

  card_decode u_decode (
    .idx_i    (idx_q),
    .rank_o   (dec_rank),
    .suit_o   (dec_suit),
    .points_o (dec_points)
  );

  // Free-running seed source; wraps naturally at 2^WIDTH.
  always_ff @(posedge clk_2K or negedge i_Reset) begin
    if (!i_Reset) begin
      free_q <= '0;
    end else begin
      free_q <= free_q + 1'b1;
    end
  end

  // Dealer FSM with registered counter controls, strobe and card outputs.
  always_ff @(posedge clk_2K or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q      <= IDLE;
      idx_q        <= 6'd0;
      used_q       <= '0;
      cards_left_q <= FULL_DECK;
      act_q        <= 1'b0;
      rst_cnt_q    <= 1'b0;
      valid_q      <= 1'b0;
      rank_q       <= 4'd0;
      suit_q       <= 2'd0;
      points_q     <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          // Shuffle takes priority so a simultaneous request cannot draw from a stale mask.
          if (i_Shuffle) begin
            used_q       <= '0;
            cards_left_q <= FULL_DECK;
          end else if (i_Request && !deck_empty) begin
            idx_q   <= seed_idx;
            act_q   <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (i_TwoSec) begin
            act_q     <= 1'b0;
            rst_cnt_q <= 1'b1;
            state_q   <= PROBE;
          end
        end
        PROBE: begin
          rst_cnt_q <= 1'b0;
          // A free slot always exists here: entry required a non-empty deck.
          if (!used_q[idx_q]) begin
            used_q[idx_q] <= 1'b1;
            cards_left_q  <= cards_left_q - 6'd1;
            rank_q        <= dec_rank;
            suit_q        <= dec_suit;
            points_q      <= dec_points;
            valid_q       <= 1'b1;
            state_q       <= DONE;
          end else begin
            idx_q <= idx_d;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          act_q     <= 1'b0;
          rst_cnt_q <= 1'b0;
          valid_q   <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign o_ActCounter = act_q;
  assign o_RstCounter = rst_cnt_q;
  assign o_Rank       = rank_q;
  assign o_Suit       = suit_q;
  assign o_Points     = points_q;
  assign o_CardValid  = valid_q;
  assign o_Busy       = (state_q != IDLE);
  assign o_DeckEmpty  = deck_empty;
  assign o_CardsLeft  = cards_left_q;

endmodule

// File: tb/tb_card_dealer.sv
module tb_card_dealer;

  logic       clk_2K = 1'b0;
  logic       i_Reset = 1'b0;
  logic       i_Request = 1'b0;
  logic       i_Shuffle = 1'b0;
  logic       i_TwoSec = 1'b0;
  logic       o_ActCounter;
  logic       o_RstCounter;
  logic [3:0] o_Rank;
  logic [1:0] o_Suit;
  logic [3:0] o_Points;
  logic       o_CardValid;
  logic       o_Busy;
  logic       o_DeckEmpty;
  logic [5:0] o_CardsLeft;

  always #5 clk_2K = ~clk_2K;

  card_dealer #(.WIDTH(12), .DECK_SIZE(52)) dut (
    .clk_2K       (clk_2K),
    .i_Reset      (i_Reset),
    .i_Request    (i_Request),
    .i_Shuffle    (i_Shuffle),
    .i_TwoSec     (i_TwoSec),
    .o_ActCounter (o_ActCounter),
    .o_RstCounter (o_RstCounter),
    .o_Rank       (o_Rank),
    .o_Suit       (o_Suit),
    .o_Points     (o_Points),
    .o_CardValid  (o_CardValid),
    .o_Busy       (o_Busy),
    .o_DeckEmpty  (o_DeckEmpty),
    .o_CardsLeft  (o_CardsLeft)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model of the seed counter: counts posedges since reset release, modulo 2^12.
  int free = 0;
  always @(posedge clk_2K or negedge i_Reset) begin
    if (!i_Reset) free <= 0;
    else          free <= (free + 1) % 4096;
  end

  // Strobe monitor: total strobes and any strobe lasting more than one cycle.
  int   strobes = 0;
  int   double_strobe = 0;
  logic prev_valid = 1'b0;
  always @(negedge clk_2K) begin
    if (o_CardValid) strobes++;
    if (o_CardValid && prev_valid) double_strobe++;
    prev_valid = o_CardValid;
  end

  logic rst_first;
  logic act_first;
  logic rst_at_valid;
  logic [51:0] seen;
  int   dup;

  task automatic tick();
    @(negedge clk_2K);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One draw: optionally wait for an exact seed value, request, pulse i_TwoSec,
  // wait for the strobe. lat counts cycles from the i_TwoSec cycle to the strobe.
  task automatic draw(input int target, input int tw_delay, input logic shuf_wait,
                      input string tag, output int lat);
    int n;
    n = 0;
    if (target >= 0) begin
      while (free != target && n < 5000) begin
        tick();
        n++;
      end
      check({tag, " seed_reached"}, (n < 5000), 1);
    end
    i_Request = 1'b1;
    tick();
    i_Request = 1'b0;
    check({tag, " busy_in_wait"}, o_Busy, 1);
    check({tag, " act_in_wait"}, o_ActCounter, 1);
    if (shuf_wait) i_Shuffle = 1'b1;
    repeat (tw_delay) tick();
    i_Shuffle = 1'b0;
    i_TwoSec = 1'b1;
    tick();
    i_TwoSec = 1'b0;
    rst_first = o_RstCounter;
    act_first = o_ActCounter;
    lat = 1;
    while (!o_CardValid && lat < 60) begin
      tick();
      lat++;
    end
    rst_at_valid = o_RstCounter;
    check({tag, " strobe_seen"}, o_CardValid, 1);
    tick();
  endtask

  initial begin
    int lat;
    int id;
    int cl;

    // Reset state
    repeat (3) tick();
    check("rst_held cards_left", o_CardsLeft, 52);
    check("rst_held valid", o_CardValid, 0);
    i_Reset = 1'b1;
    tick();
    check("reset cards_left", o_CardsLeft, 52);
    check("reset deck_empty", o_DeckEmpty, 0);
    check("reset busy", o_Busy, 0);
    check("reset act", o_ActCounter, 0);
    check("reset rst_cnt", o_RstCounter, 0);
    check("reset rank", o_Rank, 0);

    // Scenario 1: seed 60 -> idx 8 -> 9 of suit 0
    draw(60, 2, 1'b0, "s1", lat);
    check("s1 rst_first_probe", rst_first, 1);
    check("s1 act_off_probe", act_first, 0);
    check("s1 rst_one_cycle", rst_at_valid, 0);
    check("s1 latency", lat, 2);
    check("s1 rank", o_Rank, 9);
    check("s1 suit", o_Suit, 0);
    check("s1 points", o_Points, 9);
    check("s1 cards_left", o_CardsLeft, 51);
    check("s1 idle_after", o_Busy, 0);

    // Scenario 2: seed 8 -> idx 8 used -> idx 9 (ten)
    draw(8, 2, 1'b0, "s2", lat);
    check("s2 latency", lat, 3);
    check("s2 rank", o_Rank, 10);
    check("s2 suit", o_Suit, 0);
    check("s2 points", o_Points, 10);
    check("s2 cards_left", o_CardsLeft, 50);

    // Scenario 3: take idx 51, then idx 51 again wraps to idx 0, then idx 12
    draw(103, 1, 1'b0, "s3a", lat);
    check("s3a rank", o_Rank, 13);
    check("s3a suit", o_Suit, 3);
    check("s3a points", o_Points, 10);
    draw(155, 1, 1'b0, "s3b", lat);
    check("s3b latency", lat, 3);
    check("s3b rank", o_Rank, 1);
    check("s3b suit", o_Suit, 0);
    check("s3b points", o_Points, 1);
    check("s3b cards_left", o_CardsLeft, 48);
    draw(220, 1, 1'b0, "s3c", lat);
    check("s3c rank", o_Rank, 13);
    check("s3c suit", o_Suit, 0);
    check("s3c points", o_Points, 10);
    check("s3c cards_left", o_CardsLeft, 47);

    // Scenario 4: deal the remaining 47 cards, each index exactly once
    seen = '0;
    seen[8] = 1'b1; seen[9] = 1'b1; seen[51] = 1'b1; seen[0] = 1'b1; seen[12] = 1'b1;
    dup = 0;
    for (int k = 0; k < 47; k++) begin
      draw(-1, 0, 1'b0, "s4", lat);
      id = (int'(o_Rank) - 1) + 13 * int'(o_Suit);
      if (id < 0 || id > 51 || seen[id]) dup++;
      else seen[id] = 1'b1;
      check("s4 points", o_Points, (o_Rank > 4'd10) ? 32'd10 : 32'(o_Rank));
      check("s4 cards_left", o_CardsLeft, 46 - k);
    end
    check("s4 no_duplicates", dup, 0);
    check("s4 all_dealt", (seen == {52{1'b1}}), 1);
    check("s4 strobes", strobes, 52);
    check("s4 deck_empty", o_DeckEmpty, 1);
    i_Request = 1'b1;
    repeat (4) begin
      tick();
      check("s4 empty_req_busy", o_Busy, 0);
    end
    i_Request = 1'b0;
    tick();
    check("s4 empty_req_no_strobe", strobes, 52);
    i_Shuffle = 1'b1;
    tick();
    i_Shuffle = 1'b0;
    check("s4 shuffle cards_left", o_CardsLeft, 52);
    check("s4 shuffle deck_empty", o_DeckEmpty, 0);

    // Scenario 5: shuffle beats request; shuffle in WAIT is ignored
    for (int k = 0; k < 5; k++) draw(-1, 0, 1'b0, "s5", lat);
    check("s5 cards_after_5", o_CardsLeft, 47);
    i_Request = 1'b1;
    i_Shuffle = 1'b1;
    tick();
    i_Request = 1'b0;
    i_Shuffle = 1'b0;
    check("s5 shuf_req cards_left", o_CardsLeft, 52);
    check("s5 shuf_req busy", o_Busy, 0);
    tick();
    check("s5 shuf_req still_idle", o_Busy, 0);
    for (int k = 0; k < 3; k++) draw(-1, 1, 1'b0, "s5b", lat);
    draw(-1, 3, 1'b1, "s5c", lat);
    check("s5 shuffle_in_wait cards_left", o_CardsLeft, 48);
    check("s5 strobes", strobes, 61);

    // Scenario 6: asynchronous reset in the middle of WAIT
    i_Request = 1'b1;
    tick();
    i_Request = 1'b0;
    check("s6 in_wait", o_Busy, 1);
    cl = strobes;
    #2 i_Reset = 1'b0;
    #1;
    check("s6 async busy", o_Busy, 0);
    check("s6 async act", o_ActCounter, 0);
    check("s6 async cards_left", o_CardsLeft, 52);
    check("s6 async valid", o_CardValid, 0);
    i_TwoSec = 1'b1;
    repeat (3) tick();
    i_TwoSec = 1'b0;
    i_Reset = 1'b1;
    repeat (3) tick();
    check("s6 no_strobe", strobes, cl);
    check("s6 idle_after", o_Busy, 0);
    check("s6 cards_after", o_CardsLeft, 52);

    check("strobe_width", double_strobe, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
